dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
- Responder end of the data bus (dbus) protocol. Accepts dbus_req_t requests from the memory stage and returns dbus_resp_t completions.
- Backed by an internal 64-bit-wide word SRAM array with configurable response latency.
- Used as the data-memory model for core bring-up and for stall/handshake verification of the memory stage.

Parameters:
- MEM_WORDS, 1024, number of 64-bit words in the array; power of two.
- LATENCY, 2, wait cycles between request acceptance and data_ok; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- dreq  input  dbus_req_t  request: valid, addr[63:0], size[2:0], strobe[7:0], data[63:0].
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[63:0].

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn). The polarity and synchronicity are fixed.
- Reset values:
  - state = IDLE; wait counter = 0.
  - dresp.addr_ok = 0, dresp.data_ok = 0, dresp.data = 64'h0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - dresp.addr_ok = dreq.valid (combinational). Acceptance happens in that cycle.
  - On acceptance, latch addr, strobe and data; load counter = LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
- WAIT:
  - Counter decrements each cycle; go to RESP on the cycle the counter reaches 1.
  - addr_ok = 0. dreq changes are ignored (the request is already latched).
- RESP:
  - dresp.data_ok = 1 for exactly one cycle.
  - Next state is always IDLE. A new request can therefore be accepted at the earliest on the cycle after data_ok.
- Latency: data_ok is asserted LATENCY+1 cycles after the acceptance cycle.
- Word index = latched addr[3+log2(MEM_WORDS)-1:3]. addr[2:0] is ignored; the data lane arrives pre-shifted by the initiator.
- Out of range = addr >= MEM_WORDS*8. Such a request still completes normally, but:
  - reads return 64'h0;
  - writes leave the array unchanged.
- Read (latched strobe == 0): dresp.data in the RESP cycle = array[index]. data is held until the next RESP; it is zero only after reset.
- Write (strobe != 0):
  - In the RESP cycle, byte i of array[index] takes data[8i+7:8i] for each strobe[i] = 1; bytes with strobe[i] = 0 are unchanged.
  - dresp.data in that cycle = 64'h0.
- size is accepted and ignored; strobe alone defines which bytes are written.
- A read issued after a write to the same word returns the updated bytes, because the write commits before IDLE is re-entered.
- valid held high through data_ok: the responder is in IDLE the cycle after RESP, so a still-high valid is accepted as a new request. Initiators must drop valid in the cycle following data_ok unless they intend a new access.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs go to 0. A pending write is discarded; a write already committed in RESP stays.
- addr_ok and data_ok are never asserted in the same cycle.

Test Plan:
- Reset: hold resetn = 0 with valid = 1 -> addr_ok = 0, data_ok = 0, data = 0. Release resetn -> addr_ok = 1 in the same cycle as valid.
- Write/read, LATENCY = 2: write addr 0x40, strobe 8'hFF, data 64'h1122334455667788 -> data_ok 3 cycles after acceptance. Then read 0x40 -> data = 64'h1122334455667788 on data_ok.
- Partial write: preload 0x40 with all ones; write strobe 8'h0F, data 64'h0 -> read 0x40 returns 64'hFFFFFFFF00000000.
- LATENCY = 0: back-to-back reads of 0x0 and 0x8, valid held continuously -> data_ok on cycles 1 and 3, addr_ok on cycles 0 and 2.
- Out of range, MEM_WORDS = 1024: write 64'hDEAD to addr 0x2000, then read 0x2000 -> data_ok for both, read data = 64'h0. Word 0 is unchanged.
- Reset mid-operation: assert resetn = 0 in WAIT during a write to 0x80 -> no data_ok, and a subsequent read of 0x80 returns the prior contents.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// ============================================================================
// dbus_sram_responder : dbus responder backed by a 64-bit word SRAM array
//                       with a fixed, parameterised response latency.
// Revision 1.0
// ============================================================================
`default_nettype none

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAT_C   = 4'(LATENCY);

    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  WAIT    = 2'd1;
    localparam logic [1:0]  RESP    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [60:0] waddr_q, waddr_d;   // byte address with addr[2:0] dropped
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;

    logic [63:0] mem_q [MEM_WORDS];

    logic          accept_w;
    logic          in_range_w;
    logic [AW-1:0] idx_w;
    logic [63:0]   resp_data_w;
    logic          wr_en_w;
    logic          unused_w;

    // size and the sub-word address bits carry no meaning for this responder
    assign unused_w = ^{dreq.size, dreq.addr[2:0]};

    assign accept_w    = resetn && (state_q == IDLE) && dreq.valid;
    assign in_range_w  = (waddr_q[60:AW] == '0);
    assign idx_w       = waddr_q[AW-1:0];
    assign resp_data_w = ((strobe_q == 8'h00) && in_range_w) ? mem_q[idx_w] : 64'h0;
    assign wr_en_w     = (state_q == RESP) && (strobe_q != 8'h00) && in_range_w;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    waddr_d  = dreq.addr[63:3];
                    strobe_d = dreq.strobe;
                    wdata_d  = dreq.data;
                    cnt_d    = LAT_C;
                    state_d  = (LAT_C == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rdata_d = resp_data_w;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            waddr_q  <= '0;
            strobe_q <= 8'h00;
            wdata_q  <= 64'h0;
            rdata_q  <= 64'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Write commits on the RESP edge so a following read sees the new bytes
    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem_q[idx_w][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Read data is visible during RESP itself, then held until the next RESP
    assign dresp.addr_ok = accept_w;
    assign dresp.data_ok = (state_q == RESP);
    assign dresp.data    = (state_q == RESP) ? resp_data_w : rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
// Testbench for dbus_sram_responder: unit 0 uses LATENCY=2, unit 1 LATENCY=0.
`default_nettype none

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    logic       clk;
    logic       resetn;
    dbus_req_t  req  [2];
    dbus_resp_t resp [2];

    int checks;
    int errors;

    logic [63:0] sb [$];
    logic [63:0] model [2][1024];

    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .dreq   (req[0]),
        .dresp  (resp[0])
    );

    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .dreq   (req[1]),
        .dresp  (resp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference expectation for one access; updates the model for in-range writes
    task automatic predict(input int u, input logic [63:0] a, input logic [7:0] s,
                           input logic [63:0] d);
        logic [63:0] e;
        logic [9:0]  ix;
        ix = a[12:3];
        e  = 64'h0;
        if (a < 64'h2000) begin
            if (s == 8'h00) begin
                e = model[u][ix];
            end else begin
                for (int i = 0; i < 8; i++)
                    if (s[i]) model[u][ix][8*i +: 8] = d[8*i +: 8];
            end
        end
        sb.push_back(e);
    endtask

    task automatic access(input int u, input logic [63:0] a, input logic [7:0] s,
                          input logic [63:0] d, input string name);
        int lat;
        bit seen;
        logic [63:0] e;
        predict(u, a, s, d);
        @(posedge clk); #1;
        req[u].valid  = 1'b1;
        req[u].addr   = a;
        req[u].size   = 3'd3;
        req[u].strobe = s;
        req[u].data   = d;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (resp[u].addr_ok) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s addr_ok: never seen, required 1", name);
        end
        @(posedge clk); #1;
        req[u].valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            lat++;
            if (resp[u].data_ok) begin
                seen = 1'b1;
                checks++;
                if (resp[u].addr_ok) begin
                    errors++;
                    $display("FAIL %s overlap: addr_ok=1 with data_ok=1, required addr_ok=0", name);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen || lat != ((u == 0) ? 3 : 1)) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0d), required %0d", name, lat, seen,
                     (u == 0) ? 3 : 1);
        end
        e = sb.pop_front();
        checks++;
        if (!seen || resp[u].data !== e) begin
            errors++;
            $display("FAIL %s data: got %h, required %h", name, resp[u].data, e);
        end
    endtask

    task automatic test_reset;
        resetn        = 1'b0;
        req[0].valid  = 1'b1;
        req[0].addr   = 64'h0;
        req[0].size   = 3'd3;
        req[0].strobe = 8'hFF;
        req[0].data   = 64'hA5A5_5A5A_0F0F_F0F0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (resp[u].addr_ok !== 1'b0 || resp[u].data_ok !== 1'b0 || resp[u].data !== 64'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got ao=%b do=%b d=%h, required 0 0 0", u,
                         resp[u].addr_ok, resp[u].data_ok, resp[u].data);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        predict(0, 64'h0, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);
        @(negedge clk);
        checks++;
        if (resp[0].addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_release addr_ok: got %b, required 1", resp[0].addr_ok);
        end
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++;
        if (resp[0].data_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_write data_ok: got %b, required 1", resp[0].data_ok);
        end
        void'(sb.pop_front());
    endtask

    task automatic test_write_read;
        access(0, 64'h40, 8'hFF, 64'h1122_3344_5566_7788, "wr_0x40");
        access(0, 64'h40, 8'h00, 64'h0, "rd_0x40");
        access(0, 64'h45, 8'h00, 64'h0, "rd_0x45_lowbits");
    endtask

    task automatic test_partial_write;
        access(0, 64'h40, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "wr_ones");
        access(0, 64'h40, 8'h0F, 64'h0, "wr_strobe0F");
        access(0, 64'h40, 8'h00, 64'h0, "rd_partial");
        checks++;
        if (resp[0].data !== 64'hFFFF_FFFF_0000_0000) begin
            errors++;
            $display("FAIL partial_const: got %h, required ffffffff00000000", resp[0].data);
        end
        access(0, 64'h48, 8'hA5, 64'h0102_0304_0506_0708, "wr_strobeA5");
        access(0, 64'h48, 8'h00, 64'h0, "rd_strobeA5");
    endtask

    task automatic test_out_of_range;
        access(0, 64'h2000, 8'hFF, 64'hDEAD, "wr_oor");
        access(0, 64'h2000, 8'h00, 64'h0, "rd_oor");
        access(0, 64'h0, 8'h00, 64'h0, "rd_word0_after_oor");
        access(0, 64'h1FF8, 8'hFF, 64'hCAFE_F00D, "wr_last");
        access(0, 64'h1FF8, 8'h00, 64'h0, "rd_last");
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        access(1, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, "l0_wr0");
        access(1, 64'h8, 8'hFF, 64'hFEDC_BA98_7654_3210, "l0_wr8");
        predict(1, 64'h0, 8'h00, 64'h0);
        predict(1, 64'h8, 8'h00, 64'h0);
        @(posedge clk); #1;
        req[1].valid = 1'b1; req[1].addr = 64'h0; req[1].strobe = 8'h00; req[1].data = 64'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (resp[1].addr_ok !== (c == 0 || c == 2) || resp[1].data_ok !== (c == 1 || c == 3)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got ao=%b do=%b, required ao=%b do=%b", c,
                         resp[1].addr_ok, resp[1].data_ok, (c == 0 || c == 2), (c == 1 || c == 3));
            end
            if (c == 1 || c == 3) begin
                e = sb.pop_front();
                checks++;
                if (resp[1].data !== e) begin
                    errors++;
                    $display("FAIL b2b_data_cycle%0d: got %h, required %h", c, resp[1].data, e);
                end
            end
            @(posedge clk); #1;
            if (c == 0) req[1].addr = 64'h8;
            if (c == 2) req[1].valid = 1'b0;
        end
    endtask

    task automatic test_reset_midop;
        bool_check_t: begin end
        access(0, 64'h80, 8'hFF, 64'h1111_1111_1111_1111, "wr_prior_0x80");
        @(posedge clk); #1;
        req[0].valid = 1'b1; req[0].addr = 64'h80; req[0].strobe = 8'hFF;
        req[0].data  = 64'h2222_2222_2222_2222;
        @(negedge clk);
        checks++;
        if (resp[0].addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL midop_accept: got %b, required 1", resp[0].addr_ok);
        end
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        resetn = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (resp[0].data_ok !== 1'b0 || resp[0].addr_ok !== 1'b0 || resp[0].data !== 64'h0) begin
                errors++;
                $display("FAIL midop_reset_cycle%0d: got ao=%b do=%b d=%h, required 0 0 0", c,
                         resp[0].addr_ok, resp[0].data_ok, resp[0].data);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        access(0, 64'h80, 8'h00, 64'h0, "rd_after_midop_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int u = 0; u < 2; u++) begin
            req[u].valid = 1'b0; req[u].addr = 64'h0; req[u].size = 3'd0;
            req[u].strobe = 8'h00; req[u].data = 64'h0;
        end
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
